// File: rtl/fast_pkg.sv
// Shared FSM states and the radius-3 circle offset table (16 ring slots
// clockwise from the top, plus the centre as slot 16).
package fast_pkg;

    localparam int NUM_SLOTS = 17;
    localparam logic [4:0] LAST_SLOT = 5'd16;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    typedef logic signed [2:0] offset_t;

    localparam offset_t DX_TABLE [NUM_SLOTS] = '{
        3'sd0,  3'sd1,  3'sd2,  3'sd3,  3'sd3,  3'sd3,  3'sd2,  3'sd1,
        3'sd0, -3'sd1, -3'sd2, -3'sd3, -3'sd3, -3'sd3, -3'sd2, -3'sd1,
        3'sd0
    };

    localparam offset_t DY_TABLE [NUM_SLOTS] = '{
        -3'sd3, -3'sd3, -3'sd2, -3'sd1,  3'sd0,  3'sd1,  3'sd2,  3'sd3,
         3'sd3,  3'sd3,  3'sd2,  3'sd1,  3'sd0, -3'sd1, -3'sd2, -3'sd3,
         3'sd0
    };

endpackage

// File: rtl/circle_offset_lut.sv
// Maps a slot index (0..16) to its signed (dx,dy) offset around the centre.
module circle_offset_lut
    import fast_pkg::*;
(
    input  logic [4:0]        slot,
    output logic signed [2:0] dx,
    output logic signed [2:0] dy
);

    always_comb begin
        dx = '0;
        dy = '0;
        if (slot <= LAST_SLOT) begin
            dx = DX_TABLE[slot];
            dy = DY_TABLE[slot];
        end
    end

endmodule

// File: rtl/circle_buffer_loader.sv
// Fetches the 16 radius-3 circle samples plus the centre pixel from a
// fixed-latency memory, one address per cycle, with clamp or zero-fill borders.
module circle_buffer_loader
    import fast_pkg::*;
#(
    parameter int PIX_W       = 8,
    parameter int COORD_W     = 9,
    parameter int IMG_W       = 320,
    parameter int IMG_H       = 240,
    parameter int RD_LAT      = 1,
    parameter int BORDER_MODE = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [COORD_W-1:0]     curr_x,
    input  logic [COORD_W-1:0]     curr_y,
    input  logic                   start,
    input  logic [PIX_W-1:0]       input_pixel,
    output logic [COORD_W-1:0]     x_addr,
    output logic [COORD_W-1:0]     y_addr,
    output logic                   rd_en,
    output logic                   busy,
    output logic                   done,
    output logic [15:0][PIX_W-1:0] buff_output,
    output logic [PIX_W-1:0]       center_value,
    output logic [16:0]            oob_mask
);

    typedef logic signed [COORD_W:0] scoord_t;

    localparam scoord_t X_MAX = scoord_t'(IMG_W - 1);
    localparam scoord_t Y_MAX = scoord_t'(IMG_H - 1);

    state_t               state;
    logic [COORD_W-1:0]   base_x;
    logic [COORD_W-1:0]   base_y;
    logic [4:0]           slot;
    logic                 slot_oob;

    logic [4:0]           next_slot;
    logic [COORD_W-1:0]   sel_x;
    logic [COORD_W-1:0]   sel_y;
    logic signed [2:0]    dx;
    logic signed [2:0]    dy;
    scoord_t              ax;
    scoord_t              ay;
    logic                 next_oob;
    logic [COORD_W-1:0]   clamp_x;
    logic [COORD_W-1:0]   clamp_y;

    logic                 pipe_valid [1:RD_LAT];
    logic [4:0]           pipe_slot  [1:RD_LAT];
    logic                 pipe_oob   [1:RD_LAT];
    logic                 cap_valid;
    logic [4:0]           cap_slot;
    logic                 cap_oob;
    logic [PIX_W-1:0]     cap_pixel;

    // In IDLE the next issue is slot 0 of the incoming centre, otherwise the
    // slot after the one currently on the bus, around the latched centre.
    always_comb begin
        next_slot = (state == IDLE) ? 5'd0 : slot + 5'd1;
        sel_x     = (state == IDLE) ? curr_x : base_x;
        sel_y     = (state == IDLE) ? curr_y : base_y;
    end

    circle_offset_lut u_lut (
        .slot (next_slot),
        .dx   (dx),
        .dy   (dy)
    );

    always_comb begin
        ax       = scoord_t'({1'b0, sel_x}) + scoord_t'(dx);
        ay       = scoord_t'({1'b0, sel_y}) + scoord_t'(dy);
        next_oob = ax[COORD_W] || (ax > X_MAX) || ay[COORD_W] || (ay > Y_MAX);
        if (ax[COORD_W])      clamp_x = '0;
        else if (ax > X_MAX)  clamp_x = X_MAX[COORD_W-1:0];
        else                  clamp_x = ax[COORD_W-1:0];
        if (ay[COORD_W])      clamp_y = '0;
        else if (ay > Y_MAX)  clamp_y = Y_MAX[COORD_W-1:0];
        else                  clamp_y = ay[COORD_W-1:0];
    end

    assign cap_valid = pipe_valid[RD_LAT];
    assign cap_slot  = pipe_slot[RD_LAT];
    assign cap_oob   = pipe_oob[RD_LAT];
    assign cap_pixel = ((BORDER_MODE == 1) && cap_oob) ? '0 : input_pixel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            base_x   <= '0;
            base_y   <= '0;
            slot     <= '0;
            slot_oob <= 1'b0;
            rd_en    <= 1'b0;
            x_addr   <= '0;
            y_addr   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state    <= FETCH;
                    base_x   <= curr_x;
                    base_y   <= curr_y;
                    busy     <= 1'b1;
                    rd_en    <= 1'b1;
                    slot     <= next_slot;
                    slot_oob <= next_oob;
                    x_addr   <= clamp_x;
                    y_addr   <= clamp_y;
                end
                FETCH: if (slot == LAST_SLOT) begin
                    state    <= DRAIN;
                    rd_en    <= 1'b0;
                    slot_oob <= 1'b0;
                    x_addr   <= '0;
                    y_addr   <= '0;
                end else begin
                    slot     <= next_slot;
                    slot_oob <= next_oob;
                    x_addr   <= clamp_x;
                    y_addr   <= clamp_y;
                end
                DRAIN: if (cap_valid && (cap_slot == LAST_SLOT)) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Slot index and oob flag travel RD_LAT cycles so they meet the returned data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 1; j <= RD_LAT; j++) begin
                pipe_valid[j] <= 1'b0;
                pipe_slot[j]  <= '0;
                pipe_oob[j]   <= 1'b0;
            end
            buff_output  <= '0;
            center_value <= '0;
            oob_mask     <= '0;
        end else begin
            pipe_valid[1] <= rd_en;
            pipe_slot[1]  <= slot;
            pipe_oob[1]   <= slot_oob;
            for (int j = 2; j <= RD_LAT; j++) begin
                pipe_valid[j] <= pipe_valid[j-1];
                pipe_slot[j]  <= pipe_slot[j-1];
                pipe_oob[j]   <= pipe_oob[j-1];
            end
            if (cap_valid) begin
                oob_mask[cap_slot] <= cap_oob;
                if (cap_slot == LAST_SLOT)
                    center_value <= cap_pixel;
                else
                    buff_output[cap_slot[3:0]] <= cap_pixel;
            end
        end
    end

endmodule
